// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with same-cycle combinational ops plus an
// iterative multiply/divide unit driving architectural HI/LO registers.
// Optional macro FAST_MUL_EN swaps the shift-add multiplier for a
// single-cycle multiplier; divide stays iterative either way.
module alu_md #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [4:0]         ALUOp,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               start,
  output logic [WIDTH-1:0]   C,
  output logic               Zero,
  output logic               Overflow,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [4:0] OP_ADDU  = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SUBU  = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_NOR   = 5'b00111;
  localparam logic [4:0] OP_XOR   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_SLL   = 5'b01011;
  localparam logic [4:0] OP_SRL   = 5'b01100;
  localparam logic [4:0] OP_SRA   = 5'b01101;
  localparam logic [4:0] OP_LUI   = 5'b01110;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MTLO  = 5'b10111;

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state, state_n;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic               neg_hi;
  logic               neg_lo;

  logic [WIDTH-1:0]   add_res;
  logic [WIDTH-1:0]   sub_res;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               is_mul;
  logic               is_div;
  logic               last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_rem_full;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;

  assign add_res   = A + B;
  assign sub_res   = A - B;
  assign Zero      = (A == B);

  assign op_signed = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
  assign a_neg     = op_signed & A[WIDTH-1];
  assign b_neg     = op_signed & B[WIDTH-1];
  assign mag_a     = a_neg ? -A : A;
  assign mag_b     = b_neg ? -B : B;
  assign is_mul    = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU);
  assign is_div    = (ALUOp == OP_DIV)  || (ALUOp == OP_DIVU);
  assign last      = (count == LAST);

  // one shift-add step: add multiplicand if the low bit is set, then shift right
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
  assign mul_res   = neg_lo ? -mul_next : mul_next;

  // one restoring-divide step: shift next dividend bit into the remainder, try subtract
  assign div_shift    = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge       = (div_shift >= {1'b0, opnd});
  assign div_rem_full = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;
  assign div_r        = div_rem_full[WIDTH-1:0];
  assign div_q        = {acc_lo[WIDTH-2:0], div_ge};

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_res;
  assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign fast_res  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif

  // same-cycle result mux and signed-overflow detection
  always_comb begin
    C        = '0;
    Overflow = 1'b0;
    case (ALUOp)
      OP_ADDU: C = add_res;
      OP_ADD: begin
        C        = add_res;
        Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUBU: C = sub_res;
      OP_SUB: begin
        C        = sub_res;
        Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  C = A & B;
      OP_OR:   C = A | B;
      OP_NOR:  C = ~(A | B);
      OP_XOR:  C = A ^ B;
      OP_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  C = B << shamt;
      OP_SRL:  C = B >> shamt;
      OP_SRA:  C = $signed(B) >>> shamt;
      OP_LUI:  C = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: C = hi;
      OP_MFLO: C = lo;
      default: C = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state logic and handshake outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_mul) begin
`ifdef FAST_MUL_EN
            state_n = S_FIN;
`else
            state_n = S_MUL;
`endif
          end else if (is_div) begin
            state_n = (B == '0) ? S_FIN : S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (last) state_n = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // operand capture, iteration datapath and HI/LO updates
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_hi <= 1'b0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && is_mul) begin
`ifdef FAST_MUL_EN
            {hi, lo} <= fast_res;
`else
            opnd   <= mag_a;
            acc_hi <= '0;
            acc_lo <= mag_b;
            neg_hi <= a_neg ^ b_neg;
            neg_lo <= a_neg ^ b_neg;
            count  <= '0;
`endif
          end else if (start && is_div) begin
            if (B == '0) begin
              hi <= A;
              lo <= '1;
            end else begin
              opnd   <= mag_b;
              acc_hi <= '0;
              acc_lo <= mag_a;
              neg_hi <= a_neg;
              neg_lo <= a_neg ^ b_neg;
              count  <= '0;
            end
          end else if (!start) begin
            if (ALUOp == OP_MTHI) hi <= A;
            if (ALUOp == OP_MTLO) lo <= A;
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= mul_next;
          count            <= count + SHAMT_W'(1);
          if (last) {hi, lo} <= mul_res;
        end
        S_DIV: begin
          acc_hi <= div_r;
          acc_lo <= div_q;
          count  <= count + SHAMT_W'(1);
          if (last) begin
            lo <= neg_lo ? -div_q : div_q;
            hi <= neg_hi ? -div_r : div_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: table-driven and randomized bench for alu_md against a
// plain-arithmetic reference model of the ALU and multiply/divide unit.
module tb_alu_md;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_ADDU  = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SUBU  = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_NOR   = 5'b00111;
  localparam logic [4:0] OP_XOR   = 5'b01000;
  localparam logic [4:0] OP_SLT   = 5'b01001;
  localparam logic [4:0] OP_SLTU  = 5'b01010;
  localparam logic [4:0] OP_SLL   = 5'b01011;
  localparam logic [4:0] OP_SRL   = 5'b01100;
  localparam logic [4:0] OP_SRA   = 5'b01101;
  localparam logic [4:0] OP_LUI   = 5'b01110;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MTLO  = 5'b10111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [4:0]  ALUOp;
  logic [4:0]  shamt;
  logic        start;
  logic [31:0] C;
  logic        Zero, Overflow, busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  alu_md #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUOp(ALUOp), .shamt(shamt),
    .start(start), .C(C), .Zero(Zero), .Overflow(Overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] c;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[15];

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic st);
    ALUOp = op;
    A     = a;
    B     = b;
    shamt = sh;
    start = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference combinational ALU from arithmetic definitions
  function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] c, output logic ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = '0;
    ov = 1'b0;
    case (op)
      OP_ADDU: c = a + b;
      OP_ADD: begin
        s  = sa + sb;
        c  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUBU: c = a - b;
      OP_SUB: begin
        s  = sa - sb;
        c  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      OP_NOR:  c = ~(a | b);
      OP_XOR:  c = a ^ b;
      OP_SLT:  c = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: c = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  c = b << sh;
      OP_SRL:  c = b >> sh;
      OP_SRA: begin
        s = sb >>> sh;
        c = s[31:0];
      end
      OP_LUI:  c = {b[15:0], 16'h0000};
      default: c = '0;
    endcase
  endfunction

  // reference multiply/divide result using 64-bit arithmetic
  function automatic void ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (op)
      OP_MULT: begin
        p  = sa * sb;
        rh = p[63:32];
        rl = p[31:0];
      end
      OP_MULTU: begin
        p  = {32'h0, a} * {32'h0, b};
        rh = p[63:32];
        rl = p[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          rh = a;
          rl = '1;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          rl = q[31:0];
          rh = r[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 0) begin
          rh = a;
          rl = '1;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // launch one multiply/divide, then check latency, busy span and HI/LO
  task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int exp_busy, cyc, busy_cnt;
    ref_md(op, a, b, eh, el);
    exp_busy = ((op == OP_DIV || op == OP_DIVU) && b == 0) ? 0 : 32;
`ifdef FAST_MUL_EN
    if (op == OP_MULT || op == OP_MULTU) exp_busy = 0;
`endif
    apply_stimulus(op, a, b, 5'd0, 1'b1);
    tick();
    apply_stimulus(OP_NOP, $urandom, $urandom, 5'd0, 1'b0);
    cyc      = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc <= 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    check_output({name, " done_cycle"}, 64'(cyc), 64'(exp_busy + 1));
    check_output({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check_output({name, " hi"}, {32'h0, hi}, {32'h0, eh});
    check_output({name, " lo"}, {32'h0, lo}, {32'h0, el});
    tick();
    check_output({name, " done_pulse_end"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ec;
    logic        eov;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    int          n_done;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
    vecs[4]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0, 1'b0};
    vecs[5]  = '{OP_SRA,  32'h00000000, 32'h80000010, 5'd4,  32'hF8000001, 1'b0, 1'b0};
    vecs[6]  = '{OP_LUI,  32'h00000000, 32'h00001234, 5'd0,  32'h12340000, 1'b0, 1'b0};
    vecs[7]  = '{OP_ADDU, 32'h00000005, 32'h00000005, 5'd0,  32'h0000000A, 1'b1, 1'b0};
    vecs[8]  = '{OP_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'h00000F0F, 1'b0, 1'b0};
    vecs[9]  = '{OP_SLL,  32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
    vecs[10] = '{OP_SRL,  32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
    vecs[11] = '{5'b11111, 32'h00000003, 32'h00000003, 5'd0, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{OP_MULT, 32'h00000002, 32'h00000003, 5'd0,  32'h00000000, 1'b0, 1'b0};
    vecs[13] = '{OP_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0};
    vecs[14] = '{OP_XOR,  32'hA5A5A5A5, 32'hFFFFFFFF, 5'd0,  32'h5A5A5A5A, 1'b0, 1'b0};

    rst = 1'b1;
    apply_stimulus(OP_NOP, '0, '0, 5'd0, 1'b0);
    repeat (2) tick();
    check_output("reset busy", {63'h0, busy}, 64'h0);
    check_output("reset done", {63'h0, done}, 64'h0);
    check_output("reset hi", {32'h0, hi}, 64'h0);
    check_output("reset lo", {32'h0, lo}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b0);
      #1;
      check_output($sformatf("vec%0d C", i), {32'h0, C}, {32'h0, vecs[i].c});
      check_output($sformatf("vec%0d Zero", i), {63'h0, Zero}, {63'h0, vecs[i].z});
      check_output($sformatf("vec%0d Overflow", i), {63'h0, Overflow}, {63'h0, vecs[i].ov});
    end

    for (int i = 0; i < 60; i++) begin
      rop = 5'($urandom_range(0, 23));
      if (rop >= 5'd16) rop = rop + 5'd8;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      apply_stimulus(rop, ra, rb, 5'($urandom_range(0, 31)), 1'b0);
      #1;
      ref_alu(rop, ra, rb, shamt, ec, eov);
      check_output($sformatf("rand%0d op%0d C", i, rop), {32'h0, C}, {32'h0, ec});
      check_output($sformatf("rand%0d Zero", i), {63'h0, Zero}, {63'h0, (ra == rb)});
      check_output($sformatf("rand%0d Overflow", i), {63'h0, Overflow}, {63'h0, eov});
    end

    apply_stimulus(OP_NOP, '0, '0, 5'd0, 1'b0);
    tick();
    run_md("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5);
    run_md("multu_max_x2", OP_MULTU, 32'hFFFFFFFF, 32'd2);
    ALUOp = OP_MFHI;
    #1;
    check_output("mfhi C", {32'h0, C}, 64'h1);
    ALUOp = OP_MFLO;
    #1;
    check_output("mflo C", {32'h0, C}, 64'hFFFFFFFE);
    ALUOp = OP_NOP;
    tick();

    run_md("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
    run_md("divu_by_zero", OP_DIVU, 32'd7, 32'd0);
    run_md("div_minneg_neg1", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_md("mult_6_neg7", OP_MULT, 32'd6, 32'hFFFFFFF9);

    for (int i = 0; i < 8; i++) begin
      rop = OP_MULT + 5'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_md($sformatf("md_rand%0d", i), rop, ra, rb);
    end

    apply_stimulus(OP_MTLO, 32'h0000ABCD, '0, 5'd0, 1'b0);
    tick();
    ALUOp = OP_NOP;
    check_output("mtlo lo", {32'h0, lo}, 64'hABCD);
    apply_stimulus(OP_MTHI, 32'h00001357, '0, 5'd0, 1'b0);
    tick();
    ALUOp = OP_NOP;
    check_output("mthi hi", {32'h0, hi}, 64'h1357);

    apply_stimulus(OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b1);
    tick();
    apply_stimulus(OP_NOP, '0, '0, 5'd0, 1'b0);
    tick();
    apply_stimulus(OP_MTHI, 32'h0000DEAD, '0, 5'd0, 1'b0);
    tick();
    apply_stimulus(OP_DIVU, 32'd1000, 32'd3, 5'd0, 1'b1);
    tick();
    apply_stimulus(OP_NOP, '0, '0, 5'd0, 1'b0);
    n_done = 0;
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    check_output("busy_ignore done_count", 64'(n_done), 64'd1);
    check_output("busy_ignore hi", {32'h0, hi}, 64'd2);
    check_output("busy_ignore lo", {32'h0, lo}, 64'd14);
    check_output("busy_ignore idle", {63'h0, busy}, 64'h0);

    apply_stimulus(OP_DIVU, 32'd1000, 32'd3, 5'd0, 1'b1);
    tick();
    apply_stimulus(OP_NOP, '0, '0, 5'd0, 1'b0);
    repeat (9) tick();
    check_output("midrst busy_before", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst busy", {63'h0, busy}, 64'h0);
    check_output("midrst done", {63'h0, done}, 64'h0);
    check_output("midrst hi", {32'h0, hi}, 64'h0);
    check_output("midrst lo", {32'h0, lo}, 64'h0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    check_output("midrst no_done", 64'(n_done), 64'd0);
    run_md("multu_6x7_after_rst", OP_MULTU, 32'd6, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Keeps the combinational ops with same-cycle results.
- Adds a sequential multiply/divide unit with architectural HI/LO registers, a start/busy/done handshake, unsigned compare and a signed-overflow flag.
- Sits in the execute stage. The control unit stalls the PC while busy=1.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of two).
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- A  input  WIDTH  operand rs
- B  input  WIDTH  operand rt
- ALUOp  input  5  operation code; codes come from ctrl_encode_def.v
- shamt  input  SHAMT_W  shift amount
- start  input  1  launch the multiply/divide op selected by ALUOp; sampled only in IDLE
- C  output  WIDTH  combinational result
- Zero  output  1  (A==B)
- Overflow  output  1  signed overflow for ADD/SUB
- busy  output  1  multiply/divide in progress
- done  output  1  one-cycle pulse when HI/LO are updated
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: only a synchronous rst with clk is honoured.
  - State←IDLE; busy=0, done=0, hi=0, lo=0; internal counter and accumulators cleared.
  - Applies mid-operation: an in-flight op is discarded and no done is produced.
- Combinational ops, result on C in the same cycle:
  - ADDU, SUBU, ADD, SUB, AND, OR, XOR, NOR.
  - SLT signed; SLTU unsigned; result is 0/1 zero-extended.
  - SLL/SRL use B shifted by shamt. SRA is arithmetic (sign-fill).
  - LUI: C = {B[WIDTH/2-1:0], WIDTH/2 zeros}.
  - MFHI: C=hi. MFLO: C=lo.
  - Undefined codes: C=0.
- Overflow = 1 only for ADD/SUB on signed overflow; 0 for every other op. C still holds the wrapped result.
- New ALUOp codes: MULT 5'b10000, MULTU 10001, DIV 10010, DIVU 10011, MFHI 10100, MFLO 10101, MTHI 10110, MTLO 10111. For these codes, C=0 except MFHI/MFLO.
- MTHI/MTLO: hi (or lo) ← A at the clock edge, only when state=IDLE and start=0. Ignored while busy.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE → MUL on start with MULT/MULTU.
  - IDLE → DIV on start with DIV/DIVU and B≠0.
  - IDLE → FIN on start with DIV/DIVU and B==0.
  - start with any other code: ignored.
  - MUL/DIV → FIN after exactly WIDTH iterations.
  - FIN → IDLE.
- Operand capture: A and B are latched when start is accepted. Later operand changes have no effect.
- Signed ops: operands converted to magnitudes, result sign-corrected.
  - Product is negative iff the operand signs differ.
  - Quotient is negative iff the signs differ; the remainder takes the dividend's sign.
- Multiply: shift-add, one bit per cycle. {hi,lo} = full 2·WIDTH product.
- Divide: restoring, one bit per cycle. lo=quotient, hi=remainder.
  - Most-negative ÷ −1: lo=most-negative, hi=0.
- Divide by zero: hi=A, lo=all ones, reached via FIN after 1 cycle.
- busy: 1 in MUL and DIV. 0 in IDLE and FIN.
- done=1 in FIN only; hi/lo hold their new values from that cycle.
- Timing from start accepted at edge t:
  - busy high from t+1 through t+WIDTH.
  - done high in cycle t+WIDTH+1.
- start asserted while busy or done is ignored. Back-to-back ops are allowed from the cycle after done.

Optional Feature:
- Macro FAST_MUL_EN.
- Defined: MULT/MULTU computed with a single-cycle multiplier. IDLE→FIN directly; busy stays 0; done one cycle after start. Divide is unchanged.
- Undefined: iterative multiplier as above, WIDTH-cycle latency.

Test Plan:
- Add/sub overflow: ADD A=0x7FFFFFFF B=1 → C=0x80000000, Overflow=1. ADDU with the same operands → same C, Overflow=0. SUB 0x80000000−1 → Overflow=1.
- Compare and shift: SLT A=0xFFFFFFFF B=1 → C=1; SLTU → C=0. SRA B=0x80000010 shamt=4 → 0xF8000001. LUI B=0x1234 → 0x12340000. Zero=1 when A==B=5.
- Multiply: MULT A=−3 B=5 with start → busy for 32 cycles, done at cycle 33, hi=0xFFFFFFFF lo=0xFFFFFFF1. MULTU A=0xFFFFFFFF B=2 → hi=1 lo=0xFFFFFFFE. Then MFHI → C=1.
- Divide: DIV A=−7 B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7 B=0 → done 1 cycle after start, hi=7, lo=0xFFFFFFFF. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Handshake and reset: start and MTHI during busy are ignored (hi unchanged, single done). MTLO A=0xABCD while idle → lo=0xABCD. rst at the 10th busy cycle → next cycle busy=0, hi=lo=0, no done; a following MULTU 6×7 → lo=42.
- With FAST_MUL_EN defined: MULT 6×−7 → done 1 cycle after start, busy never 1, lo=0xFFFFFFD6, hi=0xFFFFFFFF.
